// File: rtl/fa_exerciser_if.sv
// ---------------------------------------------------------------------------
// fa_exerciser_if
//   Bundles the five wires between the full-adder exerciser and the adder
//   under test.
//   a, b, carry_in : stimulus driven by the exerciser
//   c, carry_out   : sum / carry response driven back by the adder
//   master modport : exerciser side (drives stimulus, reads response)
//   slave modport  : adder side (reads stimulus, drives response)
// ---------------------------------------------------------------------------
interface fa_exerciser_if;
    logic a;
    logic b;
    logic carry_in;
    logic c;
    logic carry_out;

    modport master (
        output a,
        output b,
        output carry_in,
        input  c,
        input  carry_out
    );

    modport slave (
        input  a,
        input  b,
        input  carry_in,
        output c,
        output carry_out
    );
endinterface

// File: rtl/fa_exerciser.sv
// ---------------------------------------------------------------------------
// fa_exerciser
//   On-chip stimulus generator / response checker for a single-bit full
//   adder. On start it walks all 8 input vectors, holds each for MAX_COUNT
//   settle cycles, samples the adder response for one cycle, and records
//   mismatches against the ideal sum/carry.
//
//   clk       : system clock, all state on rising edge
//   rst       : synchronous, active-high reset
//   start     : level-sampled launch, honoured only in IDLE or DONE
//   fa        : adder bus (master side: a/b/carry_in out, c/carry_out in)
//   busy      : high in DRIVE / SETTLE / CHECK
//   done      : high while in DONE
//   pass      : done with zero mismatches
//   err_count : number of mismatching vectors this run (0..8)
//   fail_mask : bit i set when vector i mismatched
//   vec_idx   : vector currently applied (a=bit0, b=bit1, carry_in=bit2)
// ---------------------------------------------------------------------------
module fa_exerciser #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter int          CNT_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fa_exerciser_if.master       fa,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [3:0]           err_count,
    output logic [7:0]           fail_mask,
    output logic [2:0]           vec_idx
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 24'd1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    logic             exp_c;
    logic             exp_co;
    logic             mismatch;

    // Stimulus comes straight from the vec_idx flops, so each bit is glitch-free.
    assign fa.a        = vec_idx[0];
    assign fa.b        = vec_idx[1];
    assign fa.carry_in = vec_idx[2];

    assign exp_c    = vec_idx[0] ^ vec_idx[1] ^ vec_idx[2];
    assign exp_co   = (vec_idx[0] & vec_idx[1]) | (vec_idx[0] & vec_idx[2]) |
                      (vec_idx[1] & vec_idx[2]);
    assign mismatch = (fa.c != exp_c) || (fa.carry_out != exp_co);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      state_next = SETTLE;
            SETTLE:     if (counter == LAST) state_next = CHECK;
            CHECK:      state_next = (vec_idx == 3'd7) ? DONE : DRIVE;
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        unique case (state)
            DRIVE, SETTLE, CHECK: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (err_count == 4'd0);
            end
            default: ;
        endcase
    end

    // Vector index, settle counter and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx   <= 3'd0;
            counter   <= '0;
            err_count <= 4'd0;
            fail_mask <= 8'h00;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_idx   <= 3'd0;
                        counter   <= '0;
                        err_count <= 4'd0;
                        fail_mask <= 8'h00;
                    end
                end
                DRIVE: counter <= '0;
                // Counter stops at LAST, so it can never wrap.
                SETTLE: if (counter != LAST) counter <= counter + 1'b1;
                // The adder response is only looked at in this single cycle.
                CHECK: begin
                    if (mismatch) begin
                        err_count          <= err_count + 4'd1;
                        fail_mask[vec_idx] <= 1'b1;
                    end
                    if (vec_idx != 3'd7) vec_idx <= vec_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
